// File: rtl/uart_rx_byte.sv
// UART 8N1 receiver: synchronizes and oversamples rx, frames a character, strobes rx_done per good byte.
// Optional parity bit checking is enabled by defining UART_RX_PARITY_EN.
module uart_rx_byte #(
    parameter int unsigned CLK_FREQ = 12000000,
    parameter int unsigned BAUD     = 9600
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       rx_done,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int unsigned HALF_LAST    = CLKS_PER_BIT / 2 - 1;
    localparam int unsigned BIT_LAST     = CLKS_PER_BIT - 1;

    generate
        if (CLKS_PER_BIT < 4) begin : g_cpb_check
            $error("uart_rx_byte: CLK_FREQ/BAUD must be at least 4");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         idx_q, idx_d;
    logic [7:0]         shift_q, shift_d;
    logic [7:0]         byte_d;
    logic               done_d, ferr_d, perr_d, busy_d;
    logic               rx_meta, rxs, rxs_d;
`ifdef UART_RX_PARITY_EN
    logic               par_bad_q, par_bad_d;
`endif

    // Two-flop synchronizer plus one delayed copy for falling-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            rxs_d   <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
            rxs_d   <= rxs;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            rx_byte    <= 8'h00;
            rx_done    <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            busy       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            rx_byte    <= byte_d;
            rx_done    <= done_d;
            frame_err  <= ferr_d;
            parity_err <= perr_d;
            busy       <= busy_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q  <= par_bad_d;
`endif
        end
    end

    // Next-state and next-output logic; all sample points fall mid-bit
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        idx_d   = idx_q;
        shift_d = shift_q;
        byte_d  = rx_byte;
        done_d  = 1'b0;
        ferr_d  = 1'b0;
        perr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = par_bad_q;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rxs && rxs_d) state_d = START;
            end
            START: begin
                if (cnt_q == CNT_W'(HALF_LAST)) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rxs ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == CNT_W'(BIT_LAST)) begin
                    cnt_d   = '0;
                    shift_d = {rxs, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
`ifdef UART_RX_PARITY_EN
                    if (idx_q == 3'd7) state_d = PARITY;
`else
                    if (idx_q == 3'd7) state_d = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_q == CNT_W'(BIT_LAST)) begin
                    cnt_d     = '0;
                    par_bad_d = (^shift_q) ^ rxs ^ PARITY_ODD;
                    state_d   = STOP;
                end
            end
`endif
            STOP: begin
                // Leave at mid-stop-bit so an immediately following start bit is caught
                if (cnt_q == CNT_W'(BIT_LAST)) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (!rxs) begin
                        ferr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                    end else if (par_bad_q) begin
                        perr_d = 1'b1;
`endif
                    end else begin
                        done_d = 1'b1;
                        byte_d = shift_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte at 10 clocks per bit; pulse monitor on the falling clock edge.
module tb_uart_rx_byte;

    localparam int CPB = 10;
`ifdef UART_RX_PARITY_EN
    localparam int LAT_MAX = 109;
`else
    localparam int LAT_MAX = 99;
`endif

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx    = 1'b1;
    logic [7:0] rx_byte;
    logic       rx_done, frame_err, parity_err, busy;

    int total = 0, bad = 0;
    int cyc = 0, start_cyc = 0, done_cyc = 0;
    int done_cnt = 0, ferr_cnt = 0, perr_cnt = 0, busy_hi = 0;
    int excl_err = 0, byte_chg_err = 0;
    logic [7:0] prev_byte = 8'h00;
`ifdef UART_RX_PARITY_EN
    logic par_flip = 1'b0;
`endif

    uart_rx_byte #(.CLK_FREQ(1000000), .BAUD(100000)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .rx_byte    (rx_byte),
        .rx_done    (rx_done),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (frame_err) ferr_cnt = ferr_cnt + 1;
        if (parity_err) perr_cnt = perr_cnt + 1;
        if (busy) busy_hi = busy_hi + 1;
        if (int'(rx_done) + int'(frame_err) + int'(parity_err) > 1) excl_err = excl_err + 1;
        if (rst_n && (rx_byte !== prev_byte) && !rx_done) byte_chg_err = byte_chg_err + 1;
        prev_byte = rx_byte;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) else begin
            bad = bad + 1;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_bit();
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_v);
        start_cyc = cyc;
        rx = 1'b0;
        wait_bit();
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_bit();
        end
`ifdef UART_RX_PARITY_EN
        rx = (^b) ^ par_flip;
        wait_bit();
`endif
        rx = stop_v;
        wait_bit();
    endtask

    initial begin
        int d0, f0, p0, b0;
        repeat (5) @(posedge clk);
        #1;
        check("rst_rx_byte", 32'(rx_byte), 32'h00);
        check("rst_rx_done", 32'(rx_done), 32'h0);
        check("rst_frame_err", 32'(frame_err), 32'h0);
        check("rst_parity_err", 32'(parity_err), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // Single character 'R'
        d0 = done_cnt;
        send_frame(8'h52, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check("r_done_pulses", 32'(done_cnt - d0), 32'd1);
        check("r_byte", 32'(rx_byte), 32'h52);
        check("r_latency", 32'(done_cyc - start_cyc <= LAT_MAX), 32'd1);
        check("r_busy_after", 32'(busy), 32'h0);

        // Back-to-back frames, first byte checked at its own stop bit
        d0 = done_cnt;
        send_frame(8'h47, 1'b1);
        check("b2b_first_byte", 32'(rx_byte), 32'h47);
        send_frame(8'h67, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check("b2b_done_pulses", 32'(done_cnt - d0), 32'd2);
        check("b2b_second_byte", 32'(rx_byte), 32'h67);

        // False start: 3-clock glitch low
        d0 = done_cnt; f0 = ferr_cnt; b0 = busy_hi;
        rx = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("fs_busy_low", 32'(busy), 32'h0);
        check("fs_busy_cycles", 32'(busy_hi - b0), 32'd5);
        repeat (20) @(posedge clk);
        #1;
        check("fs_no_done", 32'(done_cnt - d0), 32'd0);
        check("fs_no_ferr", 32'(ferr_cnt - f0), 32'd0);
        check("fs_byte_kept", 32'(rx_byte), 32'h67);

        // Framing error, then recovery after line returns high
        d0 = done_cnt; f0 = ferr_cnt;
        send_frame(8'h42, 1'b0);
        rx = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("fe_ferr_pulses", 32'(ferr_cnt - f0), 32'd1);
        check("fe_no_done", 32'(done_cnt - d0), 32'd0);
        check("fe_byte_kept", 32'(rx_byte), 32'h67);
        send_frame(8'h62, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check("fe_recover_done", 32'(done_cnt - d0), 32'd1);
        check("fe_recover_byte", 32'(rx_byte), 32'h62);

        // Reset asserted during bit 4 of 0x72
        d0 = done_cnt;
        rx = 1'b0;
        wait_bit();
        for (int i = 0; i < 4; i++) begin
            rx = (i == 1) ? 1'b1 : 1'b0;
            wait_bit();
        end
        rx = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mr_busy_reset", 32'(busy), 32'h0);
        check("mr_byte_reset", 32'(rx_byte), 32'h00);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("mr_no_pulse", 32'(done_cnt - d0), 32'd0);
        send_frame(8'h72, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check("mr_done_pulses", 32'(done_cnt - d0), 32'd1);
        check("mr_byte", 32'(rx_byte), 32'h72);

`ifdef UART_RX_PARITY_EN
        // Even parity: 0x52 has three ones so its parity bit is 1; send 0 instead
        d0 = done_cnt; p0 = perr_cnt;
        par_flip = 1'b1;
        send_frame(8'h52, 1'b1);
        par_flip = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("par_err_pulses", 32'(perr_cnt - p0), 32'd1);
        check("par_no_done", 32'(done_cnt - d0), 32'd0);
        check("par_byte_kept", 32'(rx_byte), 32'h72);
        send_frame(8'h47, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check("par_ok_done", 32'(done_cnt - d0), 32'd1);
        check("par_ok_byte", 32'(rx_byte), 32'h47);
`else
        p0 = perr_cnt;
        check("par_never", 32'(p0), 32'd0);
`endif

        check("pulses_exclusive", 32'(excl_err), 32'd0);
        check("byte_only_on_done", 32'(byte_chg_err), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
